// File: rtl/pattern_match_ctrl_pkg.sv
// Shared definitions for the serial pattern detector controller: state encoding,
// default sizes and the pattern-length clamp.
package pattern_ctrl_pkg;

   localparam int unsigned MAX_LEN_DEF = 8;
   localparam int unsigned CNT_W_DEF   = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_FILL = 2'd1;
   localparam state_t ST_RUN  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Zero-length patterns behave as one bit; oversize lengths use the full window.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      if (len == 0) return 1;
      if (len > max_len) return max_len;
      return len;
   endfunction

endpackage

// File: rtl/pattern_match_ctrl_if.sv
// Control, configuration, serial-input and status bundle of pattern_match_ctrl.
// master = host/config side, slave = the controller.
interface pattern_match_ctrl_if #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 8
);
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   logic               start;
   logic               abort;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic [CNT_W-1:0]   cfg_target;
   logic               i;
   logic               i_valid;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               busy;
   logic               done;
   logic               timeout;

   modport master (
      output start, abort, cfg_pattern, cfg_len, cfg_target, i, i_valid,
      input  match, match_cnt, busy, done, timeout
   );

   modport slave (
      input  start, abort, cfg_pattern, cfg_len, cfg_target, i, i_valid,
      output match, match_cnt, busy, done, timeout
   );

endinterface

// File: rtl/pattern_window.sv
// Serial shift window with saturating fill counter and length-masked comparator.
// filled/hit are combinational and describe the window after the current shift.
module pattern_window #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift,
   input  logic               bit_in,
   input  logic [LEN_W-1:0]   len,
   input  logic [MAX_LEN-1:0] pattern,
   output logic               filled,
   output logic               hit
);

   logic [MAX_LEN-1:0] win_q, win_d, mask;
   logic [LEN_W-1:0]   fill_q, fill_d;

   always_comb begin
      win_d  = {win_q[MAX_LEN-2:0], bit_in};
      fill_d = (fill_q >= len) ? fill_q : fill_q + 1'b1;
      mask   = ~({MAX_LEN{1'b1}} << len);
      filled = shift && (fill_d >= len);
      hit    = filled && (((win_d ^ pattern) & mask) == '0);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         win_q  <= '0;
         fill_q <= '0;
      end else if (shift) begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Programmable serial pattern detector controller: arms on start, counts overlapping matches,
// stops on target count or abort. Define MATCH_TIMEOUT_EN to add the idle-cycle timeout.
module pattern_match_ctrl
   import pattern_ctrl_pkg::*;
#(
   parameter int unsigned MAX_LEN     = MAX_LEN_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input logic                 clk,
   input logic                 rst,
   pattern_match_ctrl_if.slave bus
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   if (MAX_LEN < 2 || TIMEOUT_CYC < 2) begin : g_param_chk
      $error("pattern_match_ctrl: MAX_LEN and TIMEOUT_CYC must be >= 2");
   end

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   tgt_q, cnt_q, cnt_d;
   logic               match_q;
   logic               scanning, accept, shift, filled, hit, reached, tmo_fire;

   assign scanning = (state_q == ST_FILL) || (state_q == ST_RUN);
   assign accept   = bus.start && !bus.abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign shift    = scanning && bus.i_valid && !bus.abort;
   assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign reached  = hit && (tgt_q != '0) && (cnt_d == tgt_q);

   pattern_window #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_window (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .shift   (shift),
      .bit_in  (bus.i),
      .len     (len_q),
      .pattern (pat_q),
      .filled  (filled),
      .hit     (hit)
   );

   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (bus.start) state_d = ST_FILL;
            ST_FILL: begin
               if (reached || tmo_fire) state_d = ST_DONE;
               else if (filled)         state_d = ST_RUN;
            end
            ST_RUN:  if (reached || tmo_fire) state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         len_q   <= LEN_W'(1);
         tgt_q   <= '0;
         cnt_q   <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         match_q <= hit;
         if (accept) begin
            pat_q <= bus.cfg_pattern;
            len_q <= LEN_W'(clamp_len(32'(bus.cfg_len), MAX_LEN));
            tgt_q <= bus.cfg_target;
            cnt_q <= '0;
         end else if (hit) begin
            cnt_q <= cnt_d;
         end
      end
   end

`ifdef MATCH_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_q;
   logic             timeout_q;

   // A match in the final idle cycle takes priority over the timeout.
   assign tmo_fire = scanning && !bus.abort && !hit && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst || accept || bus.abort) begin
         tmo_q     <= '0;
         timeout_q <= 1'b0;
      end else if (scanning) begin
         tmo_q <= hit ? '0 : tmo_q + 1'b1;
         if (tmo_fire) timeout_q <= 1'b1;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign tmo_fire    = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
   assign bus.busy      = scanning;
   assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Directed bench for pattern_match_ctrl: a reference model pushes expected outputs per step
// to a scoreboard queue, popped and asserted after each clock edge.
module tb_pattern_match_ctrl;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
   localparam int unsigned TMO     = 16;

   typedef struct packed {
      logic             match;
      logic [CNT_W-1:0] cnt;
      logic             busy;
      logic             done;
      logic             tmo;
   } exp_t;

   logic tb_clk = 1'b0;
   logic rst    = 1'b1;
   int   total  = 0;
   int   bad    = 0;
   exp_t sb[$];

   // reference model state
   logic [MAX_LEN-1:0] m_hist = '0;
   logic [MAX_LEN-1:0] m_pat  = '0;
   int                 m_len = 1, m_nbits = 0, m_cnt = 0, m_tgt = 0, m_idle = 0;
   logic               m_busy = 1'b0, m_done = 1'b0, m_tmo = 1'b0;

   always #5 tb_clk = ~tb_clk;

   pattern_match_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

   pattern_match_ctrl #(
      .MAX_LEN     (MAX_LEN),
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk (tb_clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic m);
      exp_t e;
      e.match = m;
      e.cnt   = CNT_W'(m_cnt);
      e.busy  = m_busy;
      e.done  = m_done;
      e.tmo   = m_tmo;
      sb.push_back(e);
   endtask

   task automatic clk_and_check(input string tag);
      exp_t e;
      @(posedge tb_clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, ".match"},   32'(bus.match),     32'(e.match));
         check({tag, ".cnt"},     32'(bus.match_cnt), 32'(e.cnt));
         check({tag, ".busy"},    32'(bus.busy),      32'(e.busy));
         check({tag, ".done"},    32'(bus.done),      32'(e.done));
         check({tag, ".timeout"}, 32'(bus.timeout),   32'(e.tmo));
      end
   endtask

   task automatic step(input logic st, input logic ab, input logic v, input logic b,
                       input logic [MAX_LEN-1:0] pat, input int len, input int tgt,
                       input string tag);
      logic               m;
      logic [MAX_LEN-1:0] ones;
      m           = 1'b0;
      ones        = '1;
      bus.start   = st;
      bus.abort   = ab;
      bus.i_valid = v;
      bus.i       = b;
      if (st) begin
         bus.cfg_pattern = pat;
         bus.cfg_len     = LEN_W'(len);
         bus.cfg_target  = CNT_W'(tgt);
      end
      if (ab) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_tmo  = 1'b0;
      end else if (st && !m_busy) begin
         m_busy  = 1'b1;
         m_done  = 1'b0;
         m_tmo   = 1'b0;
         m_cnt   = 0;
         m_nbits = 0;
         m_idle  = 0;
         m_hist  = '0;
         m_pat   = pat;
         m_tgt   = tgt;
         m_len   = (len == 0) ? 1 : ((len > int'(MAX_LEN)) ? int'(MAX_LEN) : len);
      end else if (m_busy) begin
         if (v) begin
            m_hist = {m_hist[MAX_LEN-2:0], b};
            m_nbits++;
            if (m_nbits >= m_len &&
                ((m_hist ^ m_pat) & (ones >> (int'(MAX_LEN) - m_len))) == '0) m = 1'b1;
         end
         if (m) begin
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_idle = 0;
            if (m_tgt != 0 && m_cnt == m_tgt) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else begin
            m_idle++;
`ifdef MATCH_TIMEOUT_EN
            if (m_idle == int'(TMO)) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_tmo  = 1'b1;
            end
`endif
         end
      end
      push_exp(m);
      clk_and_check(tag);
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.i_valid = 1'b0;
      // scramble config so a design that fails to latch it is exposed
      bus.cfg_pattern = ~bus.cfg_pattern;
      bus.cfg_len     = LEN_W'(3);
      bus.cfg_target  = CNT_W'(7);
   endtask

   task automatic send(input logic v, input logic b, input string tag);
      step(1'b0, 1'b0, v, b, '0, 0, 0, tag);
   endtask

   task automatic send_seq(input logic [15:0] bits, input int n, input string tag);
      for (int k = n - 1; k >= 0; k--) send(1'b1, bits[k], $sformatf("%s[%0d]", tag, n - 1 - k));
   endtask

   task automatic do_reset(input string tag);
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.i_valid = 1'b0;
      @(posedge tb_clk);
      #1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_tmo  = 1'b0;
      m_cnt  = 0;
      m_idle = 0;
      push_exp(1'b0);
      clk_and_check(tag);
      rst = 1'b0;
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.i_valid     = 1'b0;
      bus.i           = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_target  = '0;

      do_reset("reset");

      // single match, target 1
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h0D, 4, 1, "t2_start");
      send_seq(16'b1101, 4, "t2");
      send(1'b1, 1'b1, "t2_done_hold");

      // overlapping matches, target 3
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h0D, 4, 3, "t3_start");
      send_seq(16'b1101101101, 10, "t3");

      // free-running, then abort keeps the count
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h0D, 4, 0, "t4_start");
      send_seq(16'b110101011, 9, "t4");
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 0, "t4_abort");

      // start and abort together: abort wins
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h0D, 4, 1, "start_abort");

      // i_valid gaps with i held high while invalid
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h0D, 4, 1, "t5_start");
      send(1'b1, 1'b1, "t5_a");
      send(1'b0, 1'b1, "t5_gap0");
      send(1'b1, 1'b1, "t5_b");
      send(1'b1, 1'b0, "t5_c");
      send(1'b0, 1'b1, "t5_gap1");
      send(1'b0, 1'b1, "t5_gap2");
      send(1'b1, 1'b1, "t5_d");

      // len 0 clamps to 1; start while busy is ignored
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 0, 0, "len0_start");
      send_seq(16'b01, 2, "len0");
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 4, 1, "busy_start");
      send(1'b1, 1'b1, "len0_after");
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 0, "len0_abort");

      // oversize len clamps to MAX_LEN
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 15, 1, "len15_start");
      send_seq(16'b10100101, 8, "len15");

      // reset in the middle of a run
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 2, 0, "t1_start");
      send_seq(16'b111, 3, "t1");
      do_reset("t1_reset");

`ifdef MATCH_TIMEOUT_EN
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h0D, 4, 0, "t6_start");
      for (int k = 0; k < int'(TMO); k++) send(1'b1, 1'b0, $sformatf("t6[%0d]", k));
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 0, 0, "t6_abort");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
